// File: rtl/clksw_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clksw_req_ctrl
// Description : Requester side of the HS/LS CPU clock-switch handshake.
//               Converts a per-access speed request (want_hs) into the
//               hsclk_sel level for the glitch-free clock switcher. Stalls the
//               CPU (cpu_rdy=0) until the switcher confirms the new clock.
//               Enforces a minimum LS dwell time so the clock cannot thrash.
//               Optional feature macro: CLKSW_TIMEOUT_EN. When it is defined,
//               a switch that is not acknowledged within TIMEOUT cycles raises
//               the sticky sw_timeout flag and falls back to LS. When it is
//               undefined, the switch waits indefinitely and sw_timeout is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module clksw_req_ctrl #(
    parameter int SYNC_STAGES = 2,    // flops per feedback synchroniser (>= 2)
    parameter int LS_HOLD     = 16,   // min cycles in LS_RUN before an HS switch
    parameter int TIMEOUT     = 255,  // ack timeout in cycles (timeout build only)
    parameter int CNT_W       = 8     // width of the hold and timeout counters
) (
    input  logic hsclk_in,
    input  logic rst_b,
    input  logic want_hs,
    input  logic hsclk_selected,
    input  logic lsclk_selected,
    output logic hsclk_sel,
    output logic cpu_rdy,
    output logic sw_busy,
    output logic sw_timeout
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("clksw_req_ctrl: SYNC_STAGES must be at least 2");
    end

    if ((LS_HOLD > ((2 ** CNT_W) - 1)) || (TIMEOUT > ((2 ** CNT_W) - 1))) begin : g_bad_cnt_w
        $error("clksw_req_ctrl: CNT_W too narrow for LS_HOLD or TIMEOUT");
    end

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_LS_RUN = 2'd0,
        S_TO_HS  = 2'd1,
        S_HS_RUN = 2'd2,
        S_TO_LS  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_ls_hold = CNT_W'(LS_HOLD);

    state_t                 r_state;
    logic                   r_hsclk_sel;
    logic                   r_cpu_rdy;
    logic                   r_sw_busy;
    logic [CNT_W-1:0]       r_hold_cnt;
    logic [SYNC_STAGES-1:0] r_hs_sync;
    logic [SYNC_STAGES-1:0] r_ls_sync;
    logic                   w_hs_s;
    logic                   w_ls_s;
    logic                   w_hs_ack;
    logic                   w_ls_ack;
    logic                   w_timeout_hit;

    // ------------------------------------------------------------------------
    // Feedback synchronisers
    // ------------------------------------------------------------------------
    // The switcher feedback is asynchronous to hsclk_in; shift each through a
    // SYNC_STAGES-deep flop chain before the FSM looks at it.
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_hs_sync <= '0;
            r_ls_sync <= '0;
        end else begin
            r_hs_sync <= {r_hs_sync[SYNC_STAGES-2:0], hsclk_selected};
            r_ls_sync <= {r_ls_sync[SYNC_STAGES-2:0], lsclk_selected};
        end
    end

    assign w_hs_s = r_hs_sync[SYNC_STAGES-1];
    assign w_ls_s = r_ls_sync[SYNC_STAGES-1];

    // A switch only counts as complete when exactly one clock is reported.
    // Both-high or both-low means the switcher is still mid-transition.
    assign w_hs_ack = w_hs_s && !w_ls_s;
    assign w_ls_ack = w_ls_s && !w_hs_s;

`ifdef CLKSW_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Switch acknowledge timeout
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_sw_timeout;
    logic             w_in_switch;

    assign w_in_switch   = (r_state == S_TO_HS) || (r_state == S_TO_LS);
    assign w_timeout_hit = w_in_switch && (r_to_cnt == c_timeout);

    // to_cnt is held at zero outside TO_*, so it starts from zero on entry;
    // it restarts on a timeout so a stuck TO_LS keeps retrying. The timeout
    // flag is sticky until reset.
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_to_cnt     <= '0;
            r_sw_timeout <= 1'b0;
        end else begin
            if (!w_in_switch || w_timeout_hit) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != {CNT_W{1'b1}}) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout_hit) begin
                r_sw_timeout <= 1'b1;
            end
        end
    end

    assign sw_timeout = r_sw_timeout;
`else
    // Without the timeout feature a switch waits for its ack indefinitely.
    assign w_timeout_hit = 1'b0;
    assign sw_timeout    = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Switch handshake FSM with registered outputs
    // ------------------------------------------------------------------------
    // Outputs are updated on the same edge as the state they belong to, so
    // hsclk_sel/cpu_rdy/sw_busy are always consistent with r_state.
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_LS_RUN;
            r_hsclk_sel <= 1'b0;
            r_cpu_rdy   <= 1'b1;
            r_sw_busy   <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            case (r_state)
                S_LS_RUN: begin
                    // Dwell counter runs down and saturates at zero.
                    if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                    if (want_hs && (r_hold_cnt == '0)) begin
                        r_state     <= S_TO_HS;
                        r_hsclk_sel <= 1'b1;
                        r_cpu_rdy   <= 1'b0;
                        r_sw_busy   <= 1'b1;
                    end
                end

                S_TO_HS: begin
                    // want_hs is deliberately ignored here: no abort.
                    if (w_timeout_hit) begin
                        r_state     <= S_TO_LS;
                        r_hsclk_sel <= 1'b0;
                        r_cpu_rdy   <= 1'b0;
                        r_sw_busy   <= 1'b1;
                    end else if (w_hs_ack) begin
                        r_state     <= S_HS_RUN;
                        r_hsclk_sel <= 1'b1;
                        r_cpu_rdy   <= 1'b1;
                        r_sw_busy   <= 1'b0;
                    end
                end

                S_HS_RUN: begin
                    if (!want_hs) begin
                        r_state     <= S_TO_LS;
                        r_hsclk_sel <= 1'b0;
                        r_cpu_rdy   <= 1'b0;
                        r_sw_busy   <= 1'b1;
                    end
                end

                S_TO_LS: begin
                    // A timeout here just restarts the wait (counter side);
                    // the state stays put until LS is confirmed.
                    if (!w_timeout_hit && w_ls_ack) begin
                        r_state     <= S_LS_RUN;
                        r_hsclk_sel <= 1'b0;
                        r_cpu_rdy   <= 1'b1;
                        r_sw_busy   <= 1'b0;
                        r_hold_cnt  <= c_ls_hold;
                    end
                end

                default: begin
                    r_state     <= S_LS_RUN;
                    r_hsclk_sel <= 1'b0;
                    r_cpu_rdy   <= 1'b1;
                    r_sw_busy   <= 1'b0;
                    r_hold_cnt  <= '0;
                end
            endcase
        end
    end

    assign hsclk_sel = r_hsclk_sel;
    assign cpu_rdy   = r_cpu_rdy;
    assign sw_busy   = r_sw_busy;

endmodule
`default_nettype wire
